// File: rtl/fetch_unit_pkg.sv
// ---------------------------------------------------------------------------
// fetch_unit_pkg
//   Shared constants for the instruction-fetch stage and its reservation
//   buffer: default widths/depth, the canonical NOP encoding used by decode
//   for bubble injection, and a helper that sizes buffer pointers.
//   No ports (package).
// ---------------------------------------------------------------------------
package fetch_unit_pkg;

    localparam int XLEN_DEFAULT  = 32;
    localparam int ILEN_DEFAULT  = 32;
    localparam int DEPTH_DEFAULT = 2;

    // addi x0, x0, 0
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    // Pointer width for a DEPTH-entry ring; never narrower than one bit.
    function automatic int ptr_bits(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/fetch_buf.sv
// ---------------------------------------------------------------------------
// fetch_buf
//   DEPTH-entry in-order reservation buffer. An entry is allocated when a
//   fetch is issued (pc captured), filled when its response returns (instr
//   captured, filled bit set) and popped when decode accepts it. Three
//   pointers walk the ring: wr (allocate), rsp (fill), rd (head).
//
//   clock       in   single clock, posedge
//   reset       in   asynchronous active-high; clears pointers/count/entries
//   clear       in   synchronous flush; empties the buffer, wins over all ops
//   alloc       in   allocate entry at wr with alloc_pc
//   alloc_pc    in   pc of the fetch being issued
//   fill        in   write fill_instr into entry at rsp and mark it filled
//   fill_instr  in   returned instruction
//   pop         in   release head entry (caller guarantees head_valid)
//   head_valid  out  head entry is filled
//   head_pc     out  pc of head entry
//   head_instr  out  instruction of head entry
//   full        out  all DEPTH entries allocated
// ---------------------------------------------------------------------------
module fetch_buf
    import fetch_unit_pkg::*;
#(
    parameter int XLEN  = XLEN_DEFAULT,
    parameter int ILEN  = ILEN_DEFAULT,
    parameter int DEPTH = DEPTH_DEFAULT
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            clear,
    input  logic            alloc,
    input  logic [XLEN-1:0] alloc_pc,
    input  logic            fill,
    input  logic [ILEN-1:0] fill_instr,
    input  logic            pop,
    output logic            head_valid,
    output logic [XLEN-1:0] head_pc,
    output logic [ILEN-1:0] head_instr,
    output logic            full
);

    localparam int PW = ptr_bits(DEPTH);
    localparam int CW = PW + 1;

    logic [XLEN-1:0]  pc_q    [DEPTH];
    logic [ILEN-1:0]  instr_q [DEPTH];
    logic [DEPTH-1:0] filled_q;
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rsp_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    count;

    // alloc, fill and pop always target distinct entries: alloc needs a free
    // slot (wr != rsp/rd), fill targets an unfilled entry, pop a filled one.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr   <= '0;
            rsp_ptr  <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            filled_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                pc_q[i]    <= '0;
                instr_q[i] <= '0;
            end
        end else if (clear) begin
            wr_ptr   <= '0;
            rsp_ptr  <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            filled_q <= '0;
        end else begin
            if (alloc) begin
                pc_q[wr_ptr]     <= alloc_pc;
                filled_q[wr_ptr] <= 1'b0;
                wr_ptr           <= wr_ptr + 1'b1;
            end
            if (fill) begin
                instr_q[rsp_ptr]  <= fill_instr;
                filled_q[rsp_ptr] <= 1'b1;
                rsp_ptr           <= rsp_ptr + 1'b1;
            end
            if (pop) begin
                filled_q[rd_ptr] <= 1'b0;
                rd_ptr           <= rd_ptr + 1'b1;
            end
            count <= count + CW'(alloc) - CW'(pop);
        end
    end

    assign head_valid = filled_q[rd_ptr];
    assign head_pc    = pc_q[rd_ptr];
    assign head_instr = instr_q[rd_ptr];
    assign full       = (count == CW'(DEPTH));

endmodule

// File: rtl/fetch_unit.sv
// ---------------------------------------------------------------------------
// fetch_unit
//   Instruction-fetch stage behind the PC register. Issues pc to instruction
//   memory, tracks in-order outstanding fetches in fetch_buf, presents
//   {pc, instr} to decode, and holds the PC via pc_pause unless a fetch was
//   accepted or a redirect is loading. A redirect (flush) empties the buffer
//   and converts every still-outstanding fetch into a discard credit; while
//   credits remain, responses are dropped and no new fetch is issued, so a
//   stale response can never be taken for a fresh one.
//
//   clock        in   single clock, posedge
//   reset        in   asynchronous active-high
//   pc           in   current fetch address
//   flush        in   redirect this cycle
//   pc_pause     out  1 holds the PC register
//   imem_req     out  fetch request valid
//   imem_addr    out  fetch address (= pc)
//   imem_ready   in   memory accepts the request
//   imem_rvalid  in   in-order response valid
//   imem_rdata   in   response instruction
//   id_valid     out  head entry presented to decode
//   id_pc        out  pc of head entry
//   id_instr     out  instruction of head entry
//   id_ready     in   decode accepts head
// ---------------------------------------------------------------------------
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int XLEN  = XLEN_DEFAULT,
    parameter int ILEN  = ILEN_DEFAULT,
    parameter int DEPTH = DEPTH_DEFAULT
) (
    input  logic            clock,
    input  logic            reset,
    input  logic [XLEN-1:0] pc,
    input  logic            flush,
    output logic            pc_pause,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ready,
    input  logic            imem_rvalid,
    input  logic [ILEN-1:0] imem_rdata,
    output logic            id_valid,
    output logic [XLEN-1:0] id_pc,
    output logic [ILEN-1:0] id_instr,
    input  logic            id_ready
);

    localparam int CW = ptr_bits(DEPTH) + 1;

    logic          full;
    logic          fire;
    logic          fill;
    logic          drop;
    logic          pop;
    logic          rsp_counted;
    logic [CW-1:0] outstanding;
    logic [CW-1:0] discard;
    logic [CW-1:0] pending;

    // reset gating keeps the request low and the PC held while reset is
    // asserted, since the empty buffer would otherwise ask for a fetch.
    assign imem_req  = !reset && !flush && !full && (discard == '0);
    assign imem_addr = pc;
    assign fire      = imem_req && imem_ready;
    assign pc_pause  = reset || !(fire || flush);

    // Only one of discard/outstanding is non-zero at a time (no fires while
    // discarding), so their sum is the number of responses still owed.
    assign pending     = discard + outstanding;
    assign rsp_counted = imem_rvalid && (pending != '0);
    assign drop        = imem_rvalid && (discard != '0);
    assign fill        = imem_rvalid && (discard == '0) && (outstanding != '0) && !flush;
    assign pop         = id_valid && id_ready && !flush;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            outstanding <= '0;
            discard     <= '0;
        end else if (flush) begin
            outstanding <= '0;
            discard     <= pending - CW'(rsp_counted);
        end else begin
            outstanding <= outstanding + CW'(fire) - CW'(fill);
            discard     <= discard - CW'(drop);
        end
    end

    fetch_buf #(
        .XLEN  (XLEN),
        .ILEN  (ILEN),
        .DEPTH (DEPTH)
    ) u_buf (
        .clock      (clock),
        .reset      (reset),
        .clear      (flush),
        .alloc      (fire),
        .alloc_pc   (pc),
        .fill       (fill),
        .fill_instr (imem_rdata),
        .pop        (pop),
        .head_valid (id_valid),
        .head_pc    (id_pc),
        .head_instr (id_instr),
        .full       (full)
    );

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] pc;
    logic        flush;
    logic        pc_pause;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        id_valid;
    logic [31:0] id_pc;
    logic [31:0] id_instr;
    logic        id_ready;

    int checks = 0;
    int fails  = 0;
    int n_fire = 0;

    logic [31:0] pc_m;
    logic [31:0] target;
    logic        mem_stall;
    logic [31:0] mem_q   [$];
    logic [63:0] exp_q   [$];
    logic [31:0] pop_log [$];

    fetch_unit #(.XLEN(32), .ILEN(32), .DEPTH(2)) dut (
        .clock       (clock),
        .reset       (reset),
        .pc          (pc),
        .flush       (flush),
        .pc_pause    (pc_pause),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ready  (imem_ready),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .id_valid    (id_valid),
        .id_pc       (id_pc),
        .id_instr    (id_instr),
        .id_ready    (id_ready)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] img(input logic [31:0] a);
        return {a[21:2], 12'h093};
    endfunction

    // One clock: drive memory + pc, sample before the edge, update models after.
    task automatic cycle();
        logic s_fire, s_pop, s_rv, s_flush;
        logic [31:0] s_pc;
        logic [31:0] dummy;
        pc          = pc_m;
        imem_rvalid = (mem_q.size() != 0) && !mem_stall;
        imem_rdata  = imem_rvalid ? img(mem_q[0]) : 32'h0;
        #1;
        s_fire  = imem_req && imem_ready;
        s_pop   = id_valid && id_ready;
        s_rv    = imem_rvalid;
        s_flush = flush;
        s_pc    = id_pc;
        checks++;
        if (imem_addr !== pc) begin
            fails++;
            $display("FAIL imem_addr: got %h, required %h", imem_addr, pc);
        end
        checks++;
        if (pc_pause !== !(s_fire || s_flush)) begin
            fails++;
            $display("FAIL pc_pause: got %b, required %b", pc_pause, !(s_fire || s_flush));
        end
        if (s_flush) begin
            checks++;
            if (imem_req !== 1'b0) begin
                fails++;
                $display("FAIL req_in_flush: got %b, required 0", imem_req);
            end
        end
        if (id_valid) begin
            checks++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL spurious_id_valid: got pc %h instr %h, required nothing", id_pc, id_instr);
            end else if ({id_pc, id_instr} !== exp_q[0]) begin
                fails++;
                $display("FAIL id_data: got %h/%h, required %h/%h", id_pc, id_instr,
                         exp_q[0][63:32], exp_q[0][31:0]);
            end
        end
        @(posedge clock);
        if (s_rv && mem_q.size() != 0) dummy = mem_q.pop_front();
        if (s_fire) begin
            mem_q.push_back(pc_m);
            n_fire++;
        end
        if (s_flush) begin
            exp_q.delete();
            pc_m = target;
        end else begin
            if (s_pop) begin
                if (exp_q.size() != 0) dummy = exp_q.pop_front()[63:32];
                pop_log.push_back(s_pc);
            end
            if (s_fire) begin
                exp_q.push_back({pc_m, img(pc_m)});
                pc_m = pc_m + 32'd4;
            end
        end
        @(negedge clock);
    endtask

    task automatic do_reset();
        reset       = 1'b1;
        flush       = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0;
        mem_stall   = 1'b0;
        imem_ready  = 1'b1;
        id_ready    = 1'b1;
        mem_q.delete();
        exp_q.delete();
        pop_log.delete();
        pc_m = 32'h0;
        pc   = 32'h0;
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; flush = 1'b0; imem_ready = 1'b1; id_ready = 1'b1;
        imem_rvalid = 1'b0; imem_rdata = 32'h0; pc = 32'h0; pc_m = 32'h0;
        mem_stall = 1'b0; target = 32'h0;
        #3;
        checks++; if (imem_req !== 1'b0) begin fails++; $display("FAIL reset_req: got %b, required 0", imem_req); end
        checks++; if (id_valid !== 1'b0) begin fails++; $display("FAIL reset_id_valid: got %b, required 0", id_valid); end
        checks++; if (id_pc !== 32'h0) begin fails++; $display("FAIL reset_id_pc: got %h, required 0", id_pc); end
        checks++; if (id_instr !== 32'h0) begin fails++; $display("FAIL reset_id_instr: got %h, required 0", id_instr); end
        checks++; if (pc_pause !== 1'b1) begin fails++; $display("FAIL reset_pause: got %b, required 1", pc_pause); end
        @(negedge clock);
        reset = 1'b0;
        #1;
        checks++; if (imem_req !== 1'b1) begin fails++; $display("FAIL post_reset_req: got %b, required 1", imem_req); end
        checks++; if (pc_pause !== 1'b0) begin fails++; $display("FAIL post_reset_pause: got %b, required 0", pc_pause); end
        @(negedge clock);
    endtask

    task automatic test_stream();
        do_reset();
        for (int k = 0; k < 40 && pop_log.size() < 8; k++) cycle();
        checks++;
        if (pop_log.size() < 8) begin
            fails++;
            $display("FAIL stream_timeout: got %0d pops, required 8", pop_log.size());
        end
        for (int i = 0; i < 8 && i < pop_log.size(); i++) begin
            checks++;
            if (pop_log[i] !== 32'(4 * i)) begin
                fails++;
                $display("FAIL stream_order[%0d]: got %h, required %h", i, pop_log[i], 32'(4 * i));
            end
        end
    endtask

    task automatic test_decode_stall();
        do_reset();
        id_ready = 1'b0;
        n_fire = 0;
        for (int k = 0; k < 6; k++) cycle();
        checks++; if (n_fire != 2) begin fails++; $display("FAIL dstall_fires: got %0d, required 2", n_fire); end
        checks++; if (imem_req !== 1'b0) begin fails++; $display("FAIL dstall_req: got %b, required 0", imem_req); end
        checks++; if (pc_pause !== 1'b1) begin fails++; $display("FAIL dstall_pause: got %b, required 1", pc_pause); end
        checks++; if (pc_m !== 32'h8) begin fails++; $display("FAIL dstall_pc: got %h, required 00000008", pc_m); end
        checks++; if (id_valid !== 1'b1 || id_pc !== 32'h0) begin
            fails++; $display("FAIL dstall_head: got %b/%h, required 1/00000000", id_valid, id_pc);
        end
        id_ready = 1'b1;
        for (int k = 0; k < 30 && pop_log.size() < 4; k++) cycle();
        checks++;
        if (pop_log.size() < 4) begin
            fails++;
            $display("FAIL dstall_timeout: got %0d pops, required 4", pop_log.size());
        end
        for (int i = 0; i < 4 && i < pop_log.size(); i++) begin
            checks++;
            if (pop_log[i] !== 32'(4 * i)) begin
                fails++;
                $display("FAIL dstall_order[%0d]: got %h, required %h", i, pop_log[i], 32'(4 * i));
            end
        end
    endtask

    task automatic test_imem_stall();
        do_reset();
        imem_ready = 1'b0;
        n_fire = 0;
        for (int k = 0; k < 3; k++) begin
            #0;
            checks++; if (imem_req !== 1'b1) begin fails++; $display("FAIL istall_req: got %b, required 1", imem_req); end
            checks++; if (id_valid !== 1'b0) begin fails++; $display("FAIL istall_id_valid: got %b, required 0", id_valid); end
            cycle();
        end
        checks++; if (n_fire != 0) begin fails++; $display("FAIL istall_fires: got %0d, required 0", n_fire); end
        checks++; if (pc_m !== 32'h0) begin fails++; $display("FAIL istall_pc: got %h, required 00000000", pc_m); end
        imem_ready = 1'b1;
        for (int k = 0; k < 30 && pop_log.size() < 3; k++) cycle();
        checks++;
        if (pop_log.size() < 3) begin
            fails++;
            $display("FAIL istall_timeout: got %0d pops, required 3", pop_log.size());
        end
        for (int i = 0; i < 3 && i < pop_log.size(); i++) begin
            checks++;
            if (pop_log[i] !== 32'(4 * i)) begin
                fails++;
                $display("FAIL istall_order[%0d]: got %h, required %h", i, pop_log[i], 32'(4 * i));
            end
        end
    endtask

    task automatic test_flush_inflight();
        do_reset();
        flush = 1'b1; target = 32'h10;
        cycle();
        flush = 1'b0; mem_stall = 1'b1; n_fire = 0;
        cycle();
        cycle();
        checks++; if (n_fire != 2) begin fails++; $display("FAIL fin_fires: got %0d, required 2", n_fire); end
        checks++; if (imem_req !== 1'b0) begin fails++; $display("FAIL fin_full_req: got %b, required 0", imem_req); end
        flush = 1'b1; target = 32'h100;
        cycle();
        flush = 1'b0;
        #0;
        checks++; if (imem_req !== 1'b0) begin fails++; $display("FAIL fin_discard_req: got %b, required 0", imem_req); end
        checks++; if (id_valid !== 1'b0) begin fails++; $display("FAIL fin_id_valid: got %b, required 0", id_valid); end
        cycle();
        mem_stall = 1'b0; n_fire = 0;
        cycle();
        cycle();
        checks++; if (n_fire != 0) begin fails++; $display("FAIL fin_drop_fires: got %0d, required 0", n_fire); end
        checks++; if (imem_req !== 1'b1) begin fails++; $display("FAIL fin_resume_req: got %b, required 1", imem_req); end
        pop_log.delete();
        for (int k = 0; k < 20 && pop_log.size() < 2; k++) cycle();
        checks++;
        if (pop_log.size() < 2) begin
            fails++;
            $display("FAIL fin_timeout: got %0d pops, required 2", pop_log.size());
        end else begin
            checks++;
            if (pop_log[0] !== 32'h100 || pop_log[1] !== 32'h104) begin
                fails++;
                $display("FAIL fin_order: got %h,%h, required 00000100,00000104", pop_log[0], pop_log[1]);
            end
        end
    endtask

    task automatic test_flush_rvalid();
        logic [31:0] head;
        do_reset();
        flush = 1'b1; target = 32'h20;
        cycle();
        flush = 1'b0; mem_stall = 1'b1;
        cycle();
        cycle();
        mem_stall = 1'b0; flush = 1'b1; target = 32'h200;
        cycle();
        flush = 1'b0;
        #0;
        checks++; if (imem_req !== 1'b0) begin fails++; $display("FAIL frv_discard_req: got %b, required 0", imem_req); end
        cycle();
        checks++; if (imem_req !== 1'b1) begin fails++; $display("FAIL frv_resume_req: got %b, required 1", imem_req); end
        pop_log.delete();
        for (int k = 0; k < 20 && pop_log.size() < 1; k++) cycle();
        checks++;
        if (pop_log.size() < 1) begin
            fails++;
            $display("FAIL frv_timeout: got 0 pops, required 1");
        end else begin
            checks++;
            if (pop_log[0] !== 32'h200) begin fails++; $display("FAIL frv_first: got %h, required 00000200", pop_log[0]); end
        end
        // flush coincident with a pop
        id_ready = 1'b0;
        for (int k = 0; k < 10 && !id_valid; k++) cycle();
        checks++;
        if (id_valid !== 1'b1) begin fails++; $display("FAIL fpop_setup: got id_valid %b, required 1", id_valid); end
        head = id_pc;
        id_ready = 1'b1; flush = 1'b1; target = 32'h300;
        cycle();
        flush = 1'b0;
        #0;
        checks++; if (id_valid !== 1'b0) begin fails++; $display("FAIL fpop_id_valid: got %b, required 0 (head was %h)", id_valid, head); end
        pop_log.delete();
        for (int k = 0; k < 20 && pop_log.size() < 1; k++) cycle();
        checks++;
        if (pop_log.size() < 1) begin
            fails++;
            $display("FAIL fpop_timeout: got 0 pops, required 1");
        end else begin
            checks++;
            if (pop_log[0] !== 32'h300) begin fails++; $display("FAIL fpop_first: got %h, required 00000300", pop_log[0]); end
        end
    endtask

    task automatic test_reset_midstream();
        do_reset();
        id_ready = 1'b0;
        for (int k = 0; k < 10 && !id_valid; k++) cycle();
        checks++;
        if (id_valid !== 1'b1) begin fails++; $display("FAIL mrst_setup: got id_valid %b, required 1", id_valid); end
        #2;
        reset = 1'b1;
        imem_rvalid = 1'b0;
        #1;
        checks++; if (id_valid !== 1'b0) begin fails++; $display("FAIL mrst_id_valid: got %b, required 0", id_valid); end
        checks++; if (imem_req !== 1'b0) begin fails++; $display("FAIL mrst_req: got %b, required 0", imem_req); end
        checks++; if (pc_pause !== 1'b1) begin fails++; $display("FAIL mrst_pause: got %b, required 1", pc_pause); end
        checks++; if (id_pc !== 32'h0) begin fails++; $display("FAIL mrst_id_pc: got %h, required 0", id_pc); end
        mem_q.delete();
        exp_q.delete();
        pop_log.delete();
        pc_m = 32'h0;
        @(negedge clock);
        reset = 1'b0;
        id_ready = 1'b1;
        for (int k = 0; k < 20 && pop_log.size() < 2; k++) cycle();
        checks++;
        if (pop_log.size() < 2) begin
            fails++;
            $display("FAIL mrst_timeout: got %0d pops, required 2", pop_log.size());
        end else begin
            checks++;
            if (pop_log[0] !== 32'h0 || pop_log[1] !== 32'h4) begin
                fails++;
                $display("FAIL mrst_order: got %h,%h, required 00000000,00000004", pop_log[0], pop_log[1]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_decode_stall();
        test_imem_stall();
        test_flush_inflight();
        test_flush_rvalid();
        test_reset_midstream();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
